uart_tx_arbiter: RTL

//  Shares the single UART transmitter between NUM_REQ byte producers, e.g. the BCD digit

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter state encoding, ASCII constants and
// default timing parameters used by the transmit arbiter.
package uart_pkg;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_WAIT_LO = 5'b00100,
    S_WAIT_HI = 5'b01000,
    S_GAP     = 5'b10000
  } arb_state_t;

  localparam logic [7:0]  ASCII_ZERO      = 8'd48;
  localparam int unsigned GAP_CYCLES_DEF  = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: a valid lock owner with an active request
// wins outright, otherwise the first request at or after the pointer wins.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               owner_valid,
  input  logic [IW-1:0]      owner,
  output logic [IW-1:0]      winner,
  output logic               found
);

  logic [IW-1:0] sel;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    sel    = '0;
    if (owner_valid && req[owner]) begin
      winner = owner;
      found  = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        sel = IW'((32'(ptr) + k) % NUM_REQ);
        if (!found && req[sel]) begin
          winner = sel;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers: per-byte
// round-robin with lock hold, tx_start pulse, inter-byte gap and accept timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DATA_W-1:0]   data,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        tx_done,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic          owner_valid;
  logic          aborted;
  logic [TW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] winner;
  logic          found;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .owner_valid(owner_valid),
    .owner      (owner),
    .winner     (winner),
    .found      (found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      aborted     <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx_done && found) begin
            tx_data     <= data[winner*DATA_W +: DATA_W];
            ack[winner] <= 1'b1;
            grant_id    <= winner;
            busy        <= 1'b1;
            aborted     <= 1'b0;
            state       <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          wait_cnt <= '0;
          state    <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!tx_done) begin
            state <= S_WAIT_HI;
          end else if (32'(wait_cnt) + 1 >= TIMEOUT_CYC) begin
            // Abort marks the byte so the gap exit will not re-arm the lock.
            timeout_err <= 1'b1;
            aborted     <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (32'(gap_cnt) + 1 >= GAP_CYCLES) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            rr_ptr      <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            owner       <= grant_id;
            owner_valid <= lock[grant_id] && !aborted;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
